// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_rx_ctrl_pkg;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned PRESC_W = 6;
   localparam int unsigned EDGE_W  = 5;
   localparam int unsigned BIT_W   = 3;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam logic [PRESC_W-1:0] PRESC_8  = PRESC_W'(8);
   localparam logic [PRESC_W-1:0] PRESC_16 = PRESC_W'(16);
   localparam logic [PRESC_W-1:0] PRESC_32 = PRESC_W'(32);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   function automatic logic presc_legal(input logic [PRESC_W-1:0] p);
      return (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
   endfunction

   function automatic logic exp_parity(input logic [DATA_W-1:0] d, input logic typ);
      return (typ == PAR_ODD) ? ~^d : ^d;
   endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and data-bit counter; bit_end flags the last edge of a bit.
module uart_rx_edge_bit_cnt
   import uart_rx_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic               bit_en,
   input  logic [PRESC_W-1:0] prescale_q,
   output logic [EDGE_W-1:0]  edge_cnt,
   output logic [BIT_W-1:0]   bit_cnt,
   output logic               bit_end
);

   logic [EDGE_W-1:0] edge_q, edge_d;
   logic [BIT_W-1:0]  bit_q, bit_d;

   assign bit_end  = ({1'b0, edge_q} == (prescale_q - PRESC_W'(1)));
   assign edge_cnt = edge_q;
   assign bit_cnt  = bit_q;

   always_comb begin
      edge_d = '0;
      bit_d  = '0;
      if (enable) begin
         edge_d = bit_end ? '0 : edge_q + EDGE_W'(1);
      end
      // Wraps from DATA_W-1 back to 0 on the final data boundary.
      if (bit_en) begin
         bit_d = bit_end ? bit_q + BIT_W'(1) : bit_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_q <= '0;
         bit_q  <= '0;
      end else begin
         edge_q <= edge_d;
         bit_q  <= bit_d;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detect, deserialise LSB-first, parity/stop check.
module uart_rx_ctrl
   import uart_rx_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               rx_in,
   input  logic [PRESC_W-1:0] prescale,
   input  logic               par_en,
   input  logic               par_typ,
   input  logic               sampled_bit,
   input  logic               sample_valid,
   output logic               dat_samp_en,
   output logic [EDGE_W-1:0]  edge_cnt,
   output logic [DATA_W-1:0]  p_data,
   output logic               data_valid,
   output logic               par_err,
   output logic               stp_err,
   output logic               busy
);

   rx_state_e          state_q, state_d;
   logic [PRESC_W-1:0] prescale_q, prescale_d;
   logic               par_en_q, par_en_d;
   logic               par_typ_q, par_typ_d;
   logic [DATA_W-1:0]  shreg_q, shreg_d;
   logic               cur_bit_q, cur_bit_d;
   logic [DATA_W-1:0]  p_data_q, p_data_d;
   logic               dv_q, dv_d;
   logic               par_err_q, par_err_d;
   logic               stp_err_q, stp_err_d;
   logic               bit_end;
   logic [BIT_W-1:0]   bit_cnt;
   logic               new_bit;

   uart_rx_edge_bit_cnt u_cnt (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (state_d != ST_IDLE),
      .bit_en     (state_q == ST_DATA),
      .prescale_q (prescale_q),
      .edge_cnt   (edge_cnt),
      .bit_cnt    (bit_cnt),
      .bit_end    (bit_end)
   );

   // Data bit is held until the bit boundary so a repeated sample within one bit overrides, not double-shifts.
   assign new_bit = sample_valid ? sampled_bit : cur_bit_q;

   always_comb begin
      state_d    = state_q;
      prescale_d = prescale_q;
      par_en_d   = par_en_q;
      par_typ_d  = par_typ_q;
      shreg_d    = shreg_q;
      cur_bit_d  = cur_bit_q;
      p_data_d   = p_data_q;
      dv_d       = 1'b0;
      par_err_d  = par_err_q;
      stp_err_d  = stp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (!rx_in && presc_legal(prescale)) begin
               state_d    = ST_START;
               prescale_d = prescale;
               par_en_d   = par_en;
               par_typ_d  = par_typ;
               par_err_d  = 1'b0;
               stp_err_d  = 1'b0;
            end
         end
         ST_START: begin
            if (sample_valid && sampled_bit) begin
               state_d = ST_IDLE;
            end else if (bit_end) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (sample_valid) begin
               cur_bit_d = sampled_bit;
            end
            if (bit_end) begin
               shreg_d = {new_bit, shreg_q[DATA_W-1:1]};
               if (bit_cnt == BIT_W'(DATA_W-1)) begin
                  state_d = par_en_q ? ST_PARITY : ST_STOP;
               end
            end
         end
         ST_PARITY: begin
            if (sample_valid) begin
               par_err_d = sampled_bit != exp_parity(shreg_q, par_typ_q);
            end
            if (bit_end) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (sample_valid) begin
               stp_err_d = ~sampled_bit;
               if (!par_err_q && sampled_bit) begin
                  p_data_d = shreg_q;
                  dv_d     = 1'b1;
               end
               state_d = ST_IDLE;
            end else if (bit_end) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         prescale_q <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         shreg_q    <= '0;
         cur_bit_q  <= 1'b0;
         p_data_q   <= '0;
         dv_q       <= 1'b0;
         par_err_q  <= 1'b0;
         stp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         prescale_q <= prescale_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
         shreg_q    <= shreg_d;
         cur_bit_q  <= cur_bit_d;
         p_data_q   <= p_data_d;
         dv_q       <= dv_d;
         par_err_q  <= par_err_d;
         stp_err_q  <= stp_err_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign dat_samp_en = (state_q != ST_IDLE);
   assign p_data      = p_data_q;
   assign data_valid  = dv_q;
   assign par_err     = par_err_q;
   assign stp_err     = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomised frame-level bench for uart_rx_ctrl with a per-frame arithmetic reference.
module tb_uart_rx_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       rx_in;
   logic [5:0] prescale;
   logic       par_en;
   logic       par_typ;
   logic       sampled_bit;
   logic       sample_valid;
   logic       dat_samp_en;
   logic [4:0] edge_cnt;
   logic [7:0] p_data;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;
   logic       busy;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;
   logic [7:0]  last_good = '0;
   int unsigned dv_cyc[$];
   logic [7:0]  dv_dat[$];

   uart_rx_ctrl dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .rx_in        (rx_in),
      .prescale     (prescale),
      .par_en       (par_en),
      .par_typ      (par_typ),
      .sampled_bit  (sampled_bit),
      .sample_valid (sample_valid),
      .dat_samp_en  (dat_samp_en),
      .edge_cnt     (edge_cnt),
      .p_data       (p_data),
      .data_valid   (data_valid),
      .par_err      (par_err),
      .stp_err      (stp_err),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (data_valid === 1'b1) begin
         dv_cyc.push_back(cyc);
         dv_dat.push_back(p_data);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_samp_en"}, dat_samp_en, 0);
      chk({tag, "_edge"}, edge_cnt, 0);
      chk({tag, "_p_data"}, p_data, 0);
      chk({tag, "_dv"}, data_valid, 0);
      chk({tag, "_par_err"}, par_err, 0);
      chk({tag, "_stp_err"}, stp_err, 0);
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(negedge clk);
         rx_in        = 1'b1;
         sample_valid = 1'b0;
         sampled_bit  = 1'($urandom);
      end
   endtask

   // One frame; cycle 0 is the start-detection cycle. brk: next frame starts right after the stop sample.
   task automatic run_frame(input int unsigned p, input bit pe, input bit pt, input logic [7:0] d,
                            input bit pbit, input bit sbit, input bit brk, input int abort_c);
      bit          line[11];
      int unsigned nb, s, len, det, bi, pos, mid;
      bit          exp_pe, exp_v;
      nb  = pe ? 11 : 10;
      mid = p / 2 + 2;
      line[0] = 1'b0;
      for (int unsigned i = 0; i < 8; i++) line[i+1] = d[i];
      if (pe) line[9] = pbit;
      line[nb-1] = sbit;
      s      = (nb - 1) * p + mid;
      len    = brk ? s + 1 : nb * p;
      exp_pe = pe && (pbit != 1'(($countones(d) + int'(pt)) % 2));
      exp_v  = !exp_pe && sbit;
      det    = 0;
      for (int c = 0; c < int'(len); c++) begin
         @(negedge clk);
         if (c == 0) det = cyc;
         if (c <= int'(s)) begin
            chk("edge_cnt", edge_cnt, 32'(c) % p);
            chk("busy", busy, (c != 0));
            chk("samp_en", dat_samp_en, (c != 0));
         end
         if (c == 1) begin
            chk("flags_clear_par", par_err, 0);
            chk("flags_clear_stp", stp_err, 0);
         end
         bi  = 32'(c) / p;
         pos = 32'(c) % p;
         rx_in = (bi == nb - 1 && c > int'(s)) ? 1'b1 : line[bi];
         sample_valid = (pos == mid) || (bi >= 1 && bi <= 8 && pos == 1);
         sampled_bit  = (pos == mid) ? line[bi] : 1'($urandom);
         if (c == 0) begin
            prescale = 6'(p);
            par_en   = pe;
            par_typ  = pt;
         end else begin
            prescale = 6'($urandom);
            par_en   = 1'($urandom);
            par_typ  = 1'($urandom);
         end
         if (c == abort_c) begin
            reset_n = 1'b0;
            #1;
            chk_all_zero("abort");
            repeat (2) @(negedge clk);
            rx_in = 1'b1;
            sample_valid = 1'b0;
            prescale = 6'd8;
            reset_n = 1'b1;
            last_good = '0;
            dv_cyc.delete();
            dv_dat.delete();
            return;
         end
      end
      @(posedge clk);
      #1;
      chk("dv_count", dv_cyc.size(), 32'(exp_v));
      if (exp_v && dv_cyc.size() > 0) begin
         chk("dv_cycle", dv_cyc[0], det + s + 1);
         chk("dv_data", dv_dat[0], d);
      end
      if (exp_v) last_good = d;
      chk("p_data", p_data, last_good);
      chk("par_err", par_err, exp_pe);
      chk("stp_err", stp_err, !sbit);
      chk("busy_end", busy, 0);
      dv_cyc.delete();
      dv_dat.delete();
   endtask

   task automatic glitch16();
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (c >= 1 && c <= 10) chk("glitch_busy", busy, 1);
         if (c >= 11) begin
            chk("glitch_idle", busy, 0);
            chk("glitch_edge", edge_cnt, 0);
         end
         rx_in        = (c < 3) ? 1'b0 : 1'b1;
         prescale     = (c == 0) ? 6'd16 : 6'($urandom);
         sample_valid = (c == 10);
         sampled_bit  = 1'b1;
      end
      @(posedge clk);
      #1;
      chk("glitch_dv", dv_cyc.size(), 0);
      chk("glitch_par", par_err, 0);
      chk("glitch_stp", stp_err, 0);
      chk("glitch_p_data", p_data, last_good);
      dv_cyc.delete();
      dv_dat.delete();
   endtask

   initial begin
      int unsigned p;
      bit          pe, pt, pbit, sbit, brk;
      logic [7:0]  d;
      reset_n = 1'b0;
      rx_in = 1'b1;
      prescale = 6'd8;
      par_en = 1'b0;
      par_typ = 1'b0;
      sampled_bit = 1'b0;
      sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset_n = 1'b1;
      idle(2);

      run_frame(8, 0, 0, 8'hA5, 0, 1, 0, -1);
      idle(3);
      run_frame(16, 1, 0, 8'h03, 0, 1, 0, -1);
      idle(1);
      run_frame(16, 1, 0, 8'h03, 1, 1, 0, -1);
      idle(2);
      run_frame(8, 1, 1, 8'h80, 0, 0, 0, -1);
      idle(2);
      glitch16();

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         rx_in = 1'b0;
         prescale = 6'd12;
         chk("bad_presc_busy", busy, 0);
      end
      idle(2);
      prescale = 6'd8;

      run_frame(32, 0, 0, 8'h55, 0, 1, 0, -1);
      run_frame(32, 0, 0, 8'hC3, 0, 1, 0, -1);
      idle(2);
      run_frame(8, 0, 0, 8'hE7, 0, 1, 0, 43);
      idle(2);
      run_frame(8, 0, 0, 8'h3C, 0, 1, 0, -1);
      run_frame(8, 0, 0, 8'h11, 0, 0, 1, -1);
      run_frame(8, 0, 0, 8'h22, 0, 1, 0, -1);
      idle(1);

      for (int n = 0; n < 25; n++) begin
         case ($urandom % 3)
            0: p = 8;
            1: p = 16;
            default: p = 32;
         endcase
         pe   = 1'($urandom);
         pt   = 1'($urandom);
         d    = 8'($urandom);
         pbit = 1'(($countones(d) + int'(pt)) % 2) ^ ($urandom % 4 == 0);
         sbit = ($urandom % 6) != 0;
         brk  = !sbit && 1'($urandom);
         run_frame(p, pe, pt, d, pbit, sbit, brk, -1);
         if (!brk) idle($urandom % 4);
      end
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
